// File: rtl/fp_pkg.sv
// fp_pkg: shared format helpers, state encoding and exponent masks for the FP accumulator
package fp_pkg;
  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;
  localparam logic [7:0] EXP32_ONES = 8'hFF;
  localparam logic [4:0] EXP16_ONES = 5'h1F;
  function automatic int fmt_width(bit half);
    return half ? 16 : 32;
  endfunction
  function automatic int fmt_expw(bit half);
    return half ? 5 : 8;
  endfunction
  function automatic int fmt_fracw(bit half);
    return half ? 10 : 23;
  endfunction
  function automatic int fmt_expoff(bit half);
    return half ? 15 : 127;
  endfunction
endpackage

// File: rtl/fp_add.sv
// fp_add: combinational FP32/FP16 adder, round-to-nearest-even, denormals flushed to zero
module fp_add import fp_pkg::*; #(
  parameter bit HALF = 1'b0
) (
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] sum_out
);
  localparam int W = fmt_width(HALF);
  localparam int EW = fmt_expw(HALF);
  localparam int FW = fmt_fracw(HALF);
  localparam int MW = FW + 5;
  logic [W-1:0] a, b, x, y, res;
  logic [MW-1:0] ma, mb, mr;
  logic [FW:0] rf;
  logic [EW+1:0] er;
  logic swap, sticky, up;
  int d;
  // Order by magnitude, align with sticky, add/subtract, normalise, round and pack
  always_comb begin
    a = W'(a_in);
    b = W'(b_in);
    swap = b[W-2:0] > a[W-2:0];
    x = swap ? b : a;
    y = swap ? a : b;
    d = int'(x[W-2:FW]) - int'(y[W-2:FW]);
    ma = {2'b01, x[FW-1:0], 3'b000};
    mb = {2'b01, y[FW-1:0], 3'b000};
    sticky = 1'b0;
    for (int i = 0; i < MW; i++) begin
      if (i < d) begin
        sticky = sticky | mb[0];
        mb = mb >> 1;
      end
    end
    mb[0] = mb[0] | sticky;
    mr = (x[W-1] == y[W-1]) ? ma + mb : ma - mb;
    er = {2'b00, x[W-2:FW]};
    if (mr[MW-1]) begin
      mr = {1'b0, mr[MW-1:2], mr[1] | mr[0]};
      er = er + (EW+2)'(1);
    end
    for (int i = 0; i < MW - 2; i++) begin
      if (mr != '0 && !mr[MW-2]) begin
        mr = mr << 1;
        er = er - (EW+2)'(1);
      end
    end
    up = mr[2] && (mr[1] || mr[0] || mr[3]);
    rf = {1'b0, mr[MW-3:3]} + {{FW{1'b0}}, up};
    if (rf[FW]) er = er + (EW+2)'(1);
    if (y[W-2:FW] == '0) res = (x[W-2:FW] == '0) ? {x[W-1] & y[W-1], {(W-1){1'b0}}} : x;
    else if (mr == '0) res = '0;
    else if (er[EW+1] || er == '0) res = {x[W-1], {(W-1){1'b0}}};
    else if (er[EW] || &er[EW-1:0]) res = {x[W-1], {EW{1'b1}}, {FW{1'b0}}};
    else res = {x[W-1], er[EW-1:0], rf[FW-1:0]};
    sum_out = 32'(res);
  end
endmodule

// File: rtl/fp_accum.sv
// fp_accum: streaming FP32/FP16 vector accumulator with count, overflow flag and output handshake
module fp_accum import fp_pkg::*; #(
  parameter bit HALF = 1'b0,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [CNTW-1:0] out_count,
  output logic            out_ovf
);
  localparam logic [31:0] FMT_MASK = HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  state_t state_q, state_d;
  logic [31:0] din, sum, acc_q, acc_d, out_data_q, out_data_d;
  logic [CNTW-1:0] cnt_q, cnt_d, out_count_q, out_count_d;
  logic first_q, first_d, ovf_q, ovf_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic accept, exp_ones;
  assign din = in_data & FMT_MASK;
  assign in_ready = state_q == ACC;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf = out_ovf_q;
  fp_add #(.HALF(HALF)) u_add (.a_in(acc_q), .b_in(din), .sum_out(sum));
  // Load or accumulate on accept, capture on the last beat, return to ACC on output handshake
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    first_d = first_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d = out_ovf_q;
    exp_ones = 1'b0;
    accept = in_valid && in_ready;
    if (accept) begin
      acc_d = first_q ? din : sum;
      cnt_d = first_q ? CNTW'(1) : (&cnt_q ? cnt_q : cnt_q + CNTW'(1));
      exp_ones = HALF ? (acc_d[14:10] == EXP16_ONES) : (acc_d[30:23] == EXP32_ONES);
      ovf_d = (!first_q && ovf_q) || exp_ones;
      first_d = in_last;
      if (in_last) begin
        out_data_d = acc_d;
        out_count_d = cnt_d;
        out_ovf_d = ovf_d;
        out_valid_d = 1'b1;
        state_d = HOLD;
      end
    end else if (state_q == HOLD && out_ready) begin
      out_valid_d = 1'b0;
      state_d = ACC;
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end
  // Registers; rst_n discards any partial sum without waiting for a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q <= '0;
      first_q <= 1'b1;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_count_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      first_q <= first_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q <= out_ovf_d;
    end
  end
endmodule
